// File: rtl/jtcop_pkg.sv
// Shared DEC0 CPU-side definitions: VBLANK interrupt FSM states and 68000 bus constants.
// The default IRQ level is also used by the CPU wrapper.
package jtcop_pkg;

    typedef enum logic [1:0] {
        VINT_IDLE = 2'd0,
        VINT_PEND = 2'd1,
        VINT_ACK  = 2'd2
    } vint_state_t;

    localparam logic [2:0] FC_IACK     = 3'b111;
    localparam logic [2:0] IRQ_LVL_DEF = 3'd6;
    localparam logic [2:0] IPL_NONE    = 3'b111;

endpackage

// File: rtl/jtcop_vint_edge.sv
// LVBL register and one-cycle falling-edge pulse; also reused by the object DMA logic.
module jtcop_vint_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic lvbl,
    output logic lvbl_l,
    output logic vfall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvbl_l <= 1'b1;
        else        lvbl_l <= lvbl;
    end

    assign vfall = lvbl_l & ~lvbl;

endmodule

// File: rtl/jtcop_vint.sv
// DEC0 VBLANK interrupt controller: raises IPL on LVBL fall, autovectors the IACK with VPAn.
// Optional missed-frame counter is built only when JTCOP_VINT_MISS_EN is defined.
module jtcop_vint
    import jtcop_pkg::*;
#(
    parameter logic [2:0] IRQ_LVL = IRQ_LVL_DEF,
    parameter int         MISSW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LVBL,
    output logic             LVBL_l,
    input  logic             vint_clr,
    input  logic             ASn,
    input  logic [2:0]       FC,
    input  logic [2:0]       A,
    output logic [2:0]       IPLn,
    output logic             VPAn,
    output logic             pend,
    output logic [MISSW-1:0] miss_cnt
);

    vint_state_t state, state_nxt;
    logic [2:0]  ipl_nxt;
    logic        vpa_nxt;
    logic        again, again_nxt;
    logic        vfall;
    logic        iack;

    jtcop_vint_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvbl   (LVBL),
        .lvbl_l (LVBL_l),
        .vfall  (vfall)
    );

    assign iack = ~ASn & (FC == FC_IACK) & (A == IRQ_LVL);
    assign pend = (state == VINT_PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= VINT_IDLE;
            IPLn  <= IPL_NONE;
            VPAn  <= 1'b1;
            again <= 1'b0;
        end else begin
            state <= state_nxt;
            IPLn  <= ipl_nxt;
            VPAn  <= vpa_nxt;
            again <= again_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ipl_nxt   = IPLn;
        vpa_nxt   = VPAn;
        again_nxt = again;
        case (state)
            VINT_IDLE: begin
                if (vfall) begin
                    state_nxt = VINT_PEND;
                    ipl_nxt   = ~IRQ_LVL;
                end
            end
            VINT_PEND: begin
                // A frame that starts during the IACK cycle is remembered so it is not lost
                if (iack) begin
                    state_nxt = VINT_ACK;
                    vpa_nxt   = 1'b0;
                    ipl_nxt   = IPL_NONE;
                    again_nxt = vfall;
                end else if (vint_clr) begin
                    state_nxt = VINT_IDLE;
                    ipl_nxt   = IPL_NONE;
                end
            end
            VINT_ACK: begin
                if (ASn) begin
                    vpa_nxt   = 1'b1;
                    again_nxt = 1'b0;
                    if (again || vfall) begin
                        state_nxt = VINT_PEND;
                        ipl_nxt   = ~IRQ_LVL;
                    end else begin
                        state_nxt = VINT_IDLE;
                    end
                end else if (vfall) begin
                    again_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = VINT_IDLE;
                ipl_nxt   = IPL_NONE;
                vpa_nxt   = 1'b1;
                again_nxt = 1'b0;
            end
        endcase
    end

`ifdef JTCOP_VINT_MISS_EN
    logic miss_inc;

    // A frame is lost when a pending request is cleared or overtaken without an IACK
    assign miss_inc = (state == VINT_PEND) & ~iack & (vint_clr | vfall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            miss_cnt <= '0;
        else if (miss_inc && (miss_cnt != {MISSW{1'b1}}))
            miss_cnt <= miss_cnt + 1'b1;
    end
`else
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_jtcop_vint.sv
// Self-checking bench for jtcop_vint: directed frames plus randomized bus traffic against a
// behavioural model of the interrupt request/acknowledge protocol.
module tb_jtcop_vint;

    localparam int MISSW = 4;
    localparam int MISS_MAX = (1 << MISSW) - 1;

    logic             clk;
    logic             rst_n;
    logic             LVBL;
    logic             LVBL_l;
    logic             vint_clr;
    logic             ASn;
    logic [2:0]       FC;
    logic [2:0]       A;
    logic [2:0]       IPLn;
    logic             VPAn;
    logic             pend;
    logic [MISSW-1:0] miss_cnt;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Model: is a request waiting for the CPU, is an IACK cycle open, is another frame queued
    bit m_req;
    bit m_ack;
    bit m_again;
    bit m_lvbl;
    int m_miss;

    jtcop_vint #(.IRQ_LVL(3'd6), .MISSW(MISSW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .LVBL     (LVBL),
        .LVBL_l   (LVBL_l),
        .vint_clr (vint_clr),
        .ASn      (ASn),
        .FC       (FC),
        .A        (A),
        .IPLn     (IPLn),
        .VPAn     (VPAn),
        .pend     (pend),
        .miss_cnt (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_req   = 1'b0;
        m_ack   = 1'b0;
        m_again = 1'b0;
        m_lvbl  = 1'b1;
        m_miss  = 0;
    endtask

    task automatic bumpMiss();
        if (m_miss < MISS_MAX) m_miss = m_miss + 1;
    endtask

    task automatic checkVal(input string tag, input string sig, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s %s observed=%0d expected=%0d", tag, sig, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int exp_miss;
`ifdef JTCOP_VINT_MISS_EN
        exp_miss = m_miss;
`else
        exp_miss = 0;
`endif
        checkVal(tag, "IPLn", int'(IPLn), m_req ? 1 : 7);
        checkVal(tag, "VPAn", int'(VPAn), m_ack ? 0 : 1);
        checkVal(tag, "pend", int'(pend), int'(m_req));
        checkVal(tag, "LVBL_l", int'(LVBL_l), int'(m_lvbl));
        checkVal(tag, "miss_cnt", int'(miss_cnt), exp_miss);
    endtask

    // Drives one clock of bus/video inputs (at a negedge) and advances the model to match
    task automatic applyStimulus(input logic lv, input logic asn, input logic [2:0] fc,
                                 input logic [2:0] a, input logic clr);
        bit iack, vf, n_req, n_ack, n_again;
        LVBL     = lv;
        ASn      = asn;
        FC       = fc;
        A        = a;
        vint_clr = clr;
        iack     = !asn && (fc == 3'd7) && (a == 3'd6);
        vf       = m_lvbl && !lv;
        n_req    = m_req;
        n_ack    = m_ack;
        n_again  = m_again;
        if (m_ack) begin
            if (asn) begin
                n_ack   = 1'b0;
                n_again = 1'b0;
                n_req   = m_again || vf;
            end else if (vf) begin
                n_again = 1'b1;
            end
        end else if (m_req) begin
            if (iack) begin
                n_req   = 1'b0;
                n_ack   = 1'b1;
                n_again = vf;
            end else if (clr) begin
                n_req = 1'b0;
                bumpMiss();
            end else if (vf) begin
                bumpMiss();
            end
        end else if (vf) begin
            n_req = 1'b1;
        end
        m_req   = n_req;
        m_ack   = n_ack;
        m_again = n_again;
        m_lvbl  = lv;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic lv, asn, clr;
        logic [2:0] fc, a;

        rst_n = 1'b0;
        LVBL = 1'b1; ASn = 1'b1; FC = 3'd0; A = 3'd0; vint_clr = 1'b0;
        modelReset();

        $display("[TB] reset hold with LVBL toggling");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            LVBL = ~LVBL;
            @(posedge clk);
            #2;
            checkOutput("reset");
        end
        @(negedge clk);
        LVBL  = 1'b1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("post_reset");

        $display("[TB] normal frame");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("vfall_ipl");
        applyStimulus(0, 0, 7, 6, 0);  checkOutput("iack_vpa");
        applyStimulus(0, 0, 7, 6, 0);  checkOutput("ack_hold");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("ack_release");
        applyStimulus(1, 1, 0, 0, 1);  checkOutput("clr_in_idle");

        $display("[TB] wrong level and ignored frame");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("pend2");
        applyStimulus(0, 0, 7, 3, 0);  checkOutput("wrong_lvl");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("wrong_lvl_end");
        applyStimulus(1, 1, 0, 0, 1);  checkOutput("miss_one");

        $display("[TB] collisions");
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("pend3");
        applyStimulus(0, 0, 7, 6, 1);  checkOutput("iack_vs_clr");
        applyStimulus(1, 0, 7, 6, 0);  checkOutput("ack_lvbl_rise");
        applyStimulus(0, 0, 7, 6, 0);  checkOutput("vfall_in_ack");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("again_pend");
        applyStimulus(0, 0, 7, 6, 0);  checkOutput("again_iack");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("again_done");
        applyStimulus(1, 1, 0, 0, 1);  checkOutput("again_idle");

        $display("[TB] randomized traffic");
        lv = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) lv = ~lv;
            asn = 1'($urandom_range(1));
            fc  = ($urandom_range(3) != 0) ? 3'd7 : 3'($urandom_range(7));
            a   = ($urandom_range(2) != 0) ? 3'd6 : 3'($urandom_range(7));
            clr = ($urandom_range(5) == 0);
            applyStimulus(lv, asn, fc, a, clr);
            checkOutput("random");
        end
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);

        $display("[TB] missed-frame saturation");
        for (int f = 0; f < 20; f++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(1, 1, 0, 0, 1);
            checkOutput("miss_frame");
        end

        $display("[TB] reset during acknowledge");
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 7, 6, 0);  checkOutput("pre_reset_ack");
        #2;
        rst_n = 1'b0;
        LVBL  = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, 0, 0);  checkOutput("after_reset");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("after_reset_pend");
        applyStimulus(0, 0, 7, 6, 0);  checkOutput("after_reset_ack");
        applyStimulus(0, 1, 0, 0, 0);  checkOutput("after_reset_idle");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
